// File: rtl/serial_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer_if
// Purpose  : Request/result bundle for the bit-serial adder. The sub signal
//            exists only when SERIAL_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef SERIAL_SUB_EN
    logic             sub;

    modport master (output start, a, b, sub, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, sub, output busy, done, sum, carry_out);
`else
    modport master (output start, a, b, input busy, done, sum, carry_out);
    modport slave  (input start, a, b, output busy, done, sum, carry_out);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer
// Purpose  : Bit-serial WIDTH-bit adder, one shared full-adder cell, LSB first.
//            Optional macro SERIAL_SUB_EN adds a two's-complement subtract mode.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_add_sequencer_if.slave  bus
);
    localparam int c_CNT_W = $clog2(WIDTH);
    localparam int c_PW    = WIDTH - 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_psum;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;

    logic               w_sum_bit;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_psum_next;
    logic [WIDTH-1:0]   w_opb_load;
    logic               w_carry_init;

    assign w_sum_bit    = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_carry_next = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
    assign w_psum_next  = {w_sum_bit, c_PW'(r_psum >> 1)};

`ifdef SERIAL_SUB_EN
    // A - B = A + ~B + 1: invert B and preload the carry on capture
    assign w_opb_load   = bus.b ^ {WIDTH{bus.sub}};
    assign w_carry_init = bus.sub;
`else
    assign w_opb_load   = bus.b;
    assign w_carry_init = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_psum      <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_opa   <= bus.a;
                        r_opb   <= w_opb_load;
                        r_carry <= w_carry_init;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_psum  <= w_psum_next;
                    r_carry <= w_carry_next;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    // Outputs load only here so they never expose partial sums
                    if (r_cnt == c_LAST) begin
                        r_sum       <= w_psum_next;
                        r_carry_out <= w_carry_next;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sequencer
// Purpose  : Directed self-checking bench with a result scoreboard; exercises
//            the subtract mode when SERIAL_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sequencer;
    localparam int W = 4;

    typedef struct packed {
        logic         c;
        logic [W-1:0] s;
    } res_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    res_t sb[$];
    logic [W-1:0] held_sum;
    logic         held_carry;

    serial_add_sequencer_if #(.WIDTH(W)) bus ();

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic subv);
        logic [W:0]   t;
        logic [W-1:0] beff;
        res_t         r;
        beff  = subv ? ~bv : bv;
        t     = {1'b0, av} + {1'b0, beff} + {{W{1'b0}}, subv};
        r.c   = t[W];
        r.s   = t[W-1:0];
        sb.push_back(r);
        bus.a     = av;
        bus.b     = bv;
`ifdef SERIAL_SUB_EN
        bus.sub   = subv;
`endif
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called in cycle 'lat' after the start edge; waits for done within a budget
    task automatic wait_done(input int lat0, input logic poke_in_done);
        int   lat;
        res_t r;
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 4 * W) begin
            check("busy_in_add", 32'(bus.busy), 32'd1);
            check("sum_held", 32'(bus.sum), 32'(held_sum));
            bus.a = ~bus.a;
            bus.b = ~bus.b;
            tick();
            lat++;
        end
        check("done_latency", 32'(lat), 32'(W + 1));
        check("done_seen", 32'(bus.done), 32'd1);
        check("busy_in_done", 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            r = sb.pop_front();
            check("sum", 32'(bus.sum), 32'(r.s));
            check("carry_out", 32'(bus.carry_out), 32'(r.c));
            held_sum   = r.s;
            held_carry = r.c;
        end
        if (poke_in_done) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("idle_not_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic expect_quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("no_done", 32'(bus.done), 32'd0);
            check("sum_stable", 32'(bus.sum), 32'(held_sum));
            tick();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        held_sum   = '0;
        held_carry = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
`ifdef SERIAL_SUB_EN
        bus.sub    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_carry", 32'(bus.carry_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        tick();

        start_op(4'd3, 4'd5, 1'b0);
        wait_done(1, 1'b0);
        start_op(4'd15, 4'd1, 1'b0);
        wait_done(1, 1'b0);
        // Back-to-back at full throughput, also exercises start held in DONE
        start_op(4'd15, 4'd15, 1'b0);
        wait_done(1, 1'b1);
        check("start_ignored_in_done", 32'(bus.busy), 32'd0);
        tick();

        // Re-request while busy must be dropped
        start_op(4'd2, 4'd4, 1'b0);
        tick();
        bus.a = 4'd1;
        bus.b = 4'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(3, 1'b0);
        expect_quiet(W + 2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // Abort mid-add
        start_op(4'd9, 4'd6, 1'b0);
        void'(sb.pop_front());
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        held_sum = '0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_carry", 32'(bus.carry_out), 32'd0);
        expect_quiet(W + 2);

        // start together with rst is dropped
        bus.start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_start_dropped", 32'(bus.busy), 32'd0);
        tick();
        check("rst_start_still_idle", 32'(bus.busy), 32'd0);

        start_op(4'd2, 4'd2, 1'b0);
        wait_done(1, 1'b0);

`ifdef SERIAL_SUB_EN
        start_op(4'd7, 4'd5, 1'b1);
        wait_done(1, 1'b0);
        start_op(4'd5, 4'd7, 1'b1);
        wait_done(1, 1'b0);
        start_op(4'd6, 4'd9, 1'b0);
        wait_done(1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Bit-serial adder controller that sequences a single one-bit full-adder cell over WIDTH-bit operands, one bit per clock, LSB first. It captures the operand switches on a start request, runs the add over WIDTH cycles, then presents a stable sum and carry to the LED outputs with a one-cycle done pulse. It replaces a wide ripple chain with one shared adder cell plus control, and is the first clocked block in the board-level switch/LED design.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 2..16.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an add; sampled only in IDLE
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high while the add is in progress (ADD state)
done  output  1  one-cycle pulse when a result is committed
sum  output  WIDTH  registered result; holds until the next commit
carry_out  output  1  registered carry from the MSB; holds with sum

Behaviour:
- Timing: one clock; reset synchronous, active-high. rst has priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0. The internal shift registers, carry flop and bit counter are all cleared to 0.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch a and b into the operand shift registers, clear the carry flop and the counter, then go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - busy=1.
  - Each edge: compute {c_next, s} = opA[0] + opB[0] + carry.
  - Shift s into the MSB of the partial-sum register, which shifts right.
  - Shift opA and opB right, zero-filled. Set carry <= c_next and counter <= counter + 1.
  - When counter == WIDTH-1 on an edge, process that last bit and go to DONE on the same edge.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - sum and carry_out hold the final partial-sum and carry. They are loaded on the edge entering DONE.
  - Next edge: return to IDLE unconditionally.
- Latency: start sampled at edge k, so busy is high for cycles k+1..k+WIDTH and done is high in cycle k+WIDTH+1.
- Throughput: one add per WIDTH+2 cycles. The earliest next start is sampled on the edge leaving DONE (the first IDLE-cycle edge).
- Ignored requests:
  - start is ignored in ADD and in DONE; it is not queued.
  - Changes on a or b after capture have no effect on the add in progress.
- Output stability:
  - sum and carry_out change only on the edge entering DONE (or on reset).
  - They never show partial results.
- Overflow: an unsigned overflow sets carry_out=1, and sum is the result modulo 2^WIDTH.
- Reset mid-operation: rst=1 during ADD or DONE aborts the add. Go to IDLE with all outputs at their reset values; no done pulse is produced.
- start and rst asserted together: rst wins and the request is dropped.

Optional Feature:
SERIAL_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with the operands at start.
  - When sub=1, b is bit-inverted on capture and the carry flop is initialised to 1, so the block computes A-B in two's complement.
  - carry_out=1 means no borrow (A>=B).
  - When sub=0, behaviour is identical to the add path.
- Not defined:
  - No sub port exists and the carry flop always initialises to 0.

Test Plan:
1. Reset check: rst=1 for 2 cycles, then release -> sum=0, carry_out=0, busy=0, done=0.
2. Basic add, WIDTH=4: a=3, b=5, start pulsed at edge k -> busy high for 4 cycles, done high in cycle k+5, sum=8, carry_out=0.
3. Overflow, WIDTH=4: a=15, b=1 -> sum=0, carry_out=1; a=15, b=15 -> sum=14, carry_out=1.
4. Start while busy: start at k, then re-pulse start at k+2 with a=1, b=1 -> only one done pulse, at k+5, with the first result. The second request is dropped; the prior sum holds until then.
5. Reset mid-add: start a=9, b=6, assert rst at k+2 -> IDLE next cycle, sum=0, carry_out=0, no done. A subsequent start a=2, b=2 gives sum=4.
6. SERIAL_SUB_EN, WIDTH=4:
   - sub=1, a=7, b=5 -> sum=2, carry_out=1.
   - sub=1, a=5, b=7 -> sum=14, carry_out=0.
